// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers (MULTU, MULT, DIVU, DIV, MTHI, MTLO).
// Define MULDIV_DIVIDE_EN to build the divider; without it, divide ops complete via FIX with hi/lo unchanged.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             writeHi,
    input  logic             writeLo,
    input  logic [WIDTH-1:0] writeData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned W  = WIDTH;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [2*W-1:0]  acc;
    logic [W-1:0]    mcand;
    logic            is_div;
    logic            neg_q;

    logic            a_neg;
    logic            b_neg;
    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_next;
    logic [2*W-1:0]  prod_fix;

    // Operand magnitudes; op[0] selects the signed variants.
    always_comb begin
        a_neg = op[0] & operandA[W-1];
        b_neg = op[0] & operandB[W-1];
        a_mag = a_neg ? W'(-operandA) : operandA;
        b_mag = b_neg ? W'(-operandB) : operandB;
    end

    // Shift-add step: multiplier sits in acc low half, partial product accumulates in the high half.
    always_comb begin
        mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mcand} : (W+1)'(0));
        mul_next = {mul_sum, acc[W-1:1]};
        prod_fix = neg_q ? (2*W)'(-acc) : acc;
    end

`ifdef MULDIV_DIVIDE_EN
    logic            neg_r;
    logic            div0;
    logic [W:0]      trial;
    logic [W:0]      diff;
    logic            q_bit;
    logic [2*W-1:0]  div_next;
    logic [W-1:0]    quo_fix;
    logic [W-1:0]    rem_fix;

    // Restoring step: remainder in the high half, dividend shifts out / quotient shifts in at the low half.
    always_comb begin
        trial    = acc[2*W-1:W-1];
        diff     = trial - {1'b0, mcand};
        q_bit    = (trial >= {1'b0, mcand});
        div_next = {(q_bit ? diff[W-1:0] : trial[W-1:0]), acc[W-2:0], q_bit};
        quo_fix  = div0 ? '1 : (neg_q ? W'(-acc[W-1:0]) : acc[W-1:0]);
        rem_fix  = neg_r ? W'(-acc[2*W-1:W]) : acc[2*W-1:W];
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
`ifdef MULDIV_DIVIDE_EN
            neg_r  <= 1'b0;
            div0   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div <= op[1];
                        count  <= CW'(31);
                        busy   <= 1'b1;
                        neg_q  <= a_neg ^ b_neg;
                        if (op[1]) begin
`ifdef MULDIV_DIVIDE_EN
                            acc   <= {{W{1'b0}}, a_mag};
                            mcand <= b_mag;
                            neg_r <= a_neg;
                            div0  <= (operandB == '0);
                            state <= RUN;
`else
                            state <= FIX;
`endif
                        end else begin
                            acc   <= {{W{1'b0}}, b_mag};
                            mcand <= a_mag;
                            state <= RUN;
                        end
                    end else begin
                        if (writeHi) hi <= writeData;
                        if (writeLo) lo <= writeData;
                    end
                end
                RUN: begin
`ifdef MULDIV_DIVIDE_EN
                    acc <= is_div ? div_next : mul_next;
`else
                    acc <= mul_next;
`endif
                    count <= count - CW'(1);
                    if (count == '0) state <= FIX;
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (!is_div) begin
                        hi <= prod_fix[2*W-1:W];
                        lo <= prod_fix[W-1:0];
                    end
`ifdef MULDIV_DIVIDE_EN
                    else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand and HI/LO width; only 32 is supported.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 operandA  input  32  rs value, fed from register file resultA; dividend for divides.
REQ-007 operandB  input  32  rt value, fed from register file resultB; divisor for divides.
REQ-008 writeHi  input  1  MTHI strobe.
REQ-009 writeLo  input  1  MTLO strobe.
REQ-010 writeData  input  32  data for MTHI/MTLO.
REQ-011 busy  output  1  high while an operation is in flight.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 hi  output  32  HI register: product upper word or remainder.
REQ-014 lo  output  32  LO register: product lower word or quotient.

Function
REQ-015 FSM states: IDLE, RUN, FIX; busy = (state != IDLE).
REQ-016 IDLE with start=1 at edge k:
  - latch operandA, operandB and op;
  - load iteration counter with 31;
  - go to RUN.
REQ-017 RUN:
  - one shift-add (multiply) or restoring shift-subtract (divide) step per cycle on operand magnitudes;
  - counter decrements each cycle;
  - go to FIX after counter = 0, i.e. after 32 RUN cycles.
REQ-018 FIX:
  - apply sign correction;
  - write hi/lo;
  - return to IDLE;
  - done is registered and high for exactly the one cycle following the FIX edge (edge k+34).
REQ-019 MULT: 64-bit two's-complement product; MULTU: unsigned product; hi = bits 63:32, lo = bits 31:0.
REQ-020 DIV:
  - quotient truncates toward zero;
  - remainder takes the dividend's sign;
  - 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
REQ-021 Divide by zero (DIV or DIVU): hi = dividend, lo = 0xFFFFFFFF, normal latency and done pulse.
REQ-022 start while busy: ignored, with no effect on the current operation.
REQ-023 Operand or op changes after the start edge: no effect on the result.
REQ-024 writeHi/writeLo in IDLE: load writeData into hi/lo at that edge; both may be asserted together.
REQ-025 writeHi/writeLo while busy: ignored.
REQ-026 start together with writeHi/writeLo in IDLE: start wins and the writes are dropped.
REQ-027 hi/lo hold their values at all times except in FIX (REQ-018) and on MTHI/MTLO writes (REQ-024).

Reset
REQ-028 With reset=1 at a rising edge:
  - state = IDLE, counter = 0;
  - busy = 0, done = 0;
  - hi = 0, lo = 0;
  - latched operands = 0.
REQ-029 Reset takes priority over start, writeHi and writeLo.
REQ-030 Reset during RUN or FIX aborts the operation: no done pulse, hi/lo = 0.

Configuration
REQ-031 Macro MULDIV_DIVIDE_EN defined: DIVU/DIV operate as in REQ-017 to REQ-021.
REQ-032 Macro MULDIV_DIVIDE_EN undefined:
  - no divider datapath is synthesized;
  - op 10/11 with start goes IDLE->FIX->IDLE;
  - done pulses 2 cycles after the start edge;
  - hi/lo are unchanged.

Verification
REQ-033 MULTU 0xFFFFFFFF x 0x00000002 -> hi = 0x00000001, lo = 0xFFFFFFFE; done exactly 34 cycles after the start edge; busy high for 33 cycles.
REQ-034 MULT 0xFFFFFFFD (-3) x 0x00000005 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1; then DIV 0xFFFFFFF9 (-7) / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
REQ-035 DIVU 100 / 0 -> hi = 0x00000064, lo = 0xFFFFFFFF; then DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
REQ-036 Sequence:
  - writeHi = 1 with writeData = 0x12345678 in IDLE -> hi = 0x12345678 next cycle;
  - start MULTU 3 x 4, then writeLo at RUN cycle 5 and a second start at RUN cycle 6 -> both ignored, final lo = 12, hi = 0.
REQ-037 Start MULTU 7 x 9, assert reset at RUN cycle 10 -> busy = 0 and hi = lo = 0 next cycle, no done; a fresh MULTU 7 x 9 then gives lo = 63.
REQ-038 With MULDIV_DIVIDE_EN undefined: DIVU 10 / 3 with hi = lo = 0x11111111 preloaded -> done 2 cycles after start, hi/lo still 0x11111111.
